data_mem_responder: RTL and testbench

Responder end of the processor's memory-stage request interface: accepts one read or write request at a time from the Memory stage, serves it from an internal word-addressed data RAM after a programmable number of wait states, and returns a one-cycle response. While a request is outstanding it drives `stall` so the pipeline buffers upstream of the Memory stage hold. It sits between the E/M buffer outputs and the M/W buffer inputs.

---
 rtl/data_mem_responder.sv | 113 +++++++++++
 tb/tb_data_mem_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Memory-stage responder: one request at a time, served from a local word RAM
// after WAIT wait states, with a one-cycle response strobe and pipeline stall.
//
// state | meaning
// IDLE  | ready; accepts a request when req_valid is high
// BUSY  | request latched, counting down wait states in cnt
// RESP  | rsp_valid high for one cycle, then back to IDLE
module data_mem_responder #(
  parameter int W      = 16,
  parameter int ADDR_W = 10,
  parameter int WAIT   = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic         req_write,
  input  logic [W-1:0] req_addr,
  input  logic [W-1:0] req_wdata,
  output logic         req_ready,
  output logic         rsp_valid,
  output logic [W-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam bit         ZERO_WAIT = (WAIT == 0);
  localparam logic [3:0] CNT_LOAD  = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              lat_write;
  logic [W-1:0]      lat_addr;
  logic [W-1:0]      lat_wdata;
  logic [W-1:0]      mem [2**ADDR_W];

  logic              accept;
  logic              go_resp;
  logic              acc_write;
  logic [W-1:0]      acc_addr;
  logic [W-1:0]      acc_wdata;
  logic              in_range;
  logic [ADDR_W-1:0] ram_idx;

  assign accept  = (state == IDLE) && req_valid;
  assign go_resp = (accept && ZERO_WAIT) || ((state == BUSY) && (cnt == 4'd0));

  // With no wait states the access happens on the accepting edge, before the
  // latch holds the request, so the live fields are used in IDLE.
  assign acc_write = (state == IDLE) ? req_write : lat_write;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign in_range  = ~|acc_addr[W-1:ADDR_W];
  assign ram_idx   = acc_addr[ADDR_W-1:0];

  assign req_ready = (state == IDLE);
  assign stall     = accept || (state == BUSY);

  // RAM is not reset; the rst term keeps a request seen during reset from writing.
  always_ff @(posedge clk) begin
    if (rst && go_resp && acc_write && in_range) begin
      mem[ram_idx] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            if (ZERO_WAIT) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_LOAD;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      rsp_valid <= go_resp;
      if (go_resp) begin
        rsp_err   <= ~in_range;
        rsp_rdata <= (in_range && !acc_write) ? mem[ram_idx] : '0;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: one instance with
// WAIT=2 and one with WAIT=0 sharing clock, reset and request fields.
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        rv_a, rv_z;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;

  logic        ready_a, rsp_valid_a, err_a, stall_a;
  logic [15:0] rdata_a;
  logic        ready_z, rsp_valid_z, err_z, stall_z;
  logic [15:0] rdata_z;

  logic        z_sel;
  logic        o_ready, o_rsp_valid, o_err, o_stall;
  logic [15:0] o_rdata;

  int checks = 0;
  int errors = 0;

  data_mem_responder #(.W(16), .ADDR_W(10), .WAIT(2)) dut (
    .clk(clk), .rst(rst), .req_valid(rv_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_a),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a), .rsp_err(err_a), .stall(stall_a)
  );

  data_mem_responder #(.W(16), .ADDR_W(10), .WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(rv_z), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(ready_z),
    .rsp_valid(rsp_valid_z), .rsp_rdata(rdata_z), .rsp_err(err_z), .stall(stall_z)
  );

  assign o_ready     = z_sel ? ready_z     : ready_a;
  assign o_rsp_valid = z_sel ? rsp_valid_z : rsp_valid_a;
  assign o_err       = z_sel ? err_z       : err_a;
  assign o_stall     = z_sel ? stall_z     : stall_a;
  assign o_rdata     = z_sel ? rdata_z     : rdata_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request to the selected instance and reports response latency
  // (cycles after acceptance, -1 on timeout), response fields and stall cycles.
  task automatic issue_req(input bit w, input logic [15:0] a, input logic [15:0] d,
                           input bit chg, output int lat, output logic [15:0] rd,
                           output logic er, output int stl);
    @(negedge clk);
    req_write = w; req_addr = a; req_wdata = d;
    if (z_sel) rv_z = 1'b1; else rv_a = 1'b1;
    lat = -1; rd = 16'h0; er = 1'b0; stl = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c > 0 && o_rsp_valid) begin
        lat = c; rd = o_rdata; er = o_err;
        break;
      end
      if (o_stall) stl++;
      @(negedge clk);
      if (c == 0) begin
        rv_a = 1'b0; rv_z = 1'b0;
      end
      if (chg && c == 0) begin
        req_addr = 16'h0006; req_write = 1'b1; req_wdata = 16'hDEAD;
      end
    end
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b0; rv_a = 1'b1; rv_z = 1'b0; z_sel = 1'b0;
    req_write = 1'b0; req_addr = 16'h0005; req_wdata = 16'h0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", o_rsp_valid); end
    checks++; if (o_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0000", o_rdata); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_ready); end
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL reset_stall got %b want 1", o_stall); end
    @(negedge clk);
    rst = 1'b1; rv_a = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1; if (o_rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_rsp got %b want 0", seen); end
  endtask

  task automatic test_write_read();
    int lat, stl; logic [15:0] rd; logic er;
    z_sel = 1'b0;
    issue_req(1'b1, 16'h0005, 16'hBEEF, 1'b0, lat, rd, er, stl);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency got %0d want 3", lat); end
    checks++; if (stl !== 3) begin errors++; $display("FAIL wr_stall_cycles got %0d want 3", stl); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err got %b want 0", er); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL wr_rdata got %h want 0000", rd); end
    issue_req(1'b0, 16'h0005, 16'h0, 1'b0, lat, rd, er, stl);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency got %0d want 3", lat); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data got %h want beef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd_err got %b want 0", er); end
    @(negedge clk); #1;
    checks++; if (o_rsp_valid !== 1'b0) begin errors++; $display("FAIL rsp_one_cycle got %b want 0", o_rsp_valid); end
    checks++; if (o_rdata !== 16'hBEEF) begin errors++; $display("FAIL rdata_hold got %h want beef", o_rdata); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL ready_after_resp got %b want 1", o_ready); end
  endtask

  task automatic test_wait0();
    int lat, stl; logic [15:0] rd; logic er;
    logic [7:0] pattern;
    z_sel = 1'b1;
    issue_req(1'b1, 16'h0005, 16'hBEEF, 1'b0, lat, rd, er, stl);
    issue_req(1'b0, 16'h0005, 16'h0, 1'b0, lat, rd, er, stl);
    checks++; if (lat !== 1) begin errors++; $display("FAIL w0_latency got %0d want 1", lat); end
    checks++; if (stl !== 1) begin errors++; $display("FAIL w0_stall_cycles got %0d want 1", stl); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL w0_rd_data got %h want beef", rd); end
    @(negedge clk);
    req_write = 1'b0; req_addr = 16'h0005; rv_z = 1'b1;
    pattern = 8'h0;
    for (int c = 0; c < 8; c++) begin
      #1; pattern[c] = o_rsp_valid;
      @(negedge clk);
    end
    rv_z = 1'b0;
    checks++; if (pattern !== 8'b1010_1010) begin errors++; $display("FAIL w0_continuous got %b want 10101010", pattern); end
    z_sel = 1'b0;
  endtask

  task automatic test_out_of_range();
    int lat, stl; logic [15:0] rd; logic er;
    z_sel = 1'b0;
    issue_req(1'b1, 16'h0405, 16'h1234, 1'b0, lat, rd, er, stl);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_wr_latency got %0d want 3", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_wr_err got %b want 1", er); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL oor_wr_rdata got %h want 0000", rd); end
    issue_req(1'b0, 16'h8005, 16'h0, 1'b0, lat, rd, er, stl);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_rd_err got %b want 1", er); end
    checks++; if (rd !== 16'h0) begin errors++; $display("FAIL oor_rd_rdata got %h want 0000", rd); end
    issue_req(1'b0, 16'h0005, 16'h0, 1'b0, lat, rd, er, stl);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL oor_no_alias got %h want beef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL oor_inrange_err got %b want 0", er); end
  endtask

  task automatic test_field_change();
    int lat, stl; logic [15:0] rd; logic er;
    z_sel = 1'b0;
    issue_req(1'b1, 16'h0006, 16'h6666, 1'b0, lat, rd, er, stl);
    issue_req(1'b0, 16'h0005, 16'h0, 1'b1, lat, rd, er, stl);
    checks++; if (lat !== 3) begin errors++; $display("FAIL chg_latency got %0d want 3", lat); end
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL chg_rd_data got %h want beef", rd); end
    issue_req(1'b0, 16'h0006, 16'h0, 1'b0, lat, rd, er, stl);
    checks++; if (rd !== 16'h6666) begin errors++; $display("FAIL chg_ram6_kept got %h want 6666", rd); end
  endtask

  task automatic test_reset_mid();
    int lat, stl; logic [15:0] rd; logic er;
    logic seen;
    z_sel = 1'b0;
    issue_req(1'b1, 16'h0007, 16'h2222, 1'b0, lat, rd, er, stl);
    @(negedge clk);
    req_write = 1'b1; req_addr = 16'h0007; req_wdata = 16'h5555; rv_a = 1'b1;
    @(negedge clk);
    rv_a = 1'b0;
    #1;
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL mid_busy_stall got %b want 1", o_stall); end
    rst = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready got %b want 1", o_ready); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall got %b want 0", o_stall); end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1; if (o_rsp_valid) seen = 1'b1;
      @(negedge clk);
      if (c == 2) rst = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got %b want 0", seen); end
    issue_req(1'b0, 16'h0007, 16'h0, 1'b0, lat, rd, er, stl);
    checks++; if (rd !== 16'h2222) begin errors++; $display("FAIL mid_aborted_write got %h want 2222", rd); end
    issue_req(1'b1, 16'h0007, 16'h1111, 1'b0, lat, rd, er, stl);
    issue_req(1'b0, 16'h0007, 16'h0, 1'b0, lat, rd, er, stl);
    checks++; if (rd !== 16'h1111) begin errors++; $display("FAIL mid_rewrite got %h want 1111", rd); end
    issue_req(1'b0, 16'h0005, 16'h0, 1'b0, lat, rd, er, stl);
    checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL mid_beef_kept got %h want beef", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wait0();
    test_out_of_range();
    test_field_change();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
